final_project_soc_onchip_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the SoC's 4-word, 32-bit single-port on-chip RAM (one Avalon slave port, 1-cycle read latency, byte-enabled writes). Two Avalon-MM masters, m0 and m1, share the RAM. The block serialises their transactions with round-robin priority, drives the RAM port, and returns read data with a `readdatavalid` pulse. It sits between the system interconnect and the RAM instance.

---
 rtl/final_project_soc_mem_arb_pkg.sv | 16 +
 rtl/final_project_soc_rr_arb2.sv | 24 ++
 rtl/final_project_soc_onchip_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_final_project_soc_onchip_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/final_project_soc_mem_arb_pkg.sv
// Shared types for the on-chip RAM arbiter: FSM states, requester id and
// the reset value of the round-robin history.
package final_project_soc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_e;

    typedef logic req_id_t;

    // Reset history points at m1 so m0 wins the first tie.
    localparam req_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/final_project_soc_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the requester that was not granted last.
module final_project_soc_rr_arb2
    import final_project_soc_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
        if (req != 2'b00) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/final_project_soc_onchip_mem_arbiter.sv
// Serialises two Avalon-MM masters onto a single-port 1-cycle-latency RAM:
// accept in IDLE, drive the RAM in ISSUE, capture read data in RDATA.
module final_project_soc_onchip_mem_arbiter
    import final_project_soc_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    state_e                  state_q, state_d;
    req_id_t                 last_grant_q, last_grant_d;
    req_id_t                 id_q, id_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    wr_q, wr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]              rdv_q, rdv_d;

    logic [1:0] req;
    logic [1:0] gnt;
    req_id_t    gnt_id;
    logic       accepting;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    final_project_soc_rr_arb2 u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    // Gated by reset_n so waitrequest is high for the whole reset interval.
    assign accepting      = reset_n && (state_q == IDLE);
    assign m0_waitrequest = !(accepting && gnt[0]);
    assign m1_waitrequest = !(accepting && gnt[1]);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rdv_d        = 2'b00;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    addr_d       = gnt_id ? m1_address    : m0_address;
                    be_d         = gnt_id ? m1_byteenable : m0_byteenable;
                    wdata_d      = gnt_id ? m1_writedata  : m0_writedata;
                    // read+write together is a write; the read is dropped
                    wr_d         = gnt_id ? m1_write      : m0_write;
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = wr_q ? IDLE : RDATA;
            RDATA: begin
                rdata_d[id_q] = mem_readdata;
                rdv_d[id_q]   = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_GRANT_RST;
            id_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rdv_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rdv_q        <= rdv_d;
        end
    end

    // The command latch only changes on accept, so the RAM bus holds outside ISSUE.
    assign mem_chipselect   = (state_q == ISSUE);
    assign mem_write        = (state_q == ISSUE) && wr_q;
    assign mem_address      = addr_q;
    assign mem_byteenable   = be_q;
    assign mem_writedata    = wdata_q;
    assign m0_readdata      = rdata_q[0];
    assign m1_readdata      = rdata_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];

endmodule

// File: tb/tb_final_project_soc_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural 4x32 RAM
// (registered q, byte-enabled writes) attached to the mem_* port.
module tb_final_project_soc_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [4];

    always #5 clk = ~clk;

    final_project_soc_onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit rd, input bit wr, input logic [1:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        if (id) begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end
    endtask

    task automatic do_write(input bit id, input logic [1:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        set_req(id, 1'b0, 1'b1, a, be, d);
        settle();
        chk("wr_wait", id ? m1_waitrequest : m0_waitrequest, 1'b0);
        tick();
        set_req(id, 1'b0, 1'b0, a, be, d);
        settle();
        chk("wr_mem_write", mem_write, 1'b1);
        chk("wr_mem_addr", mem_address, a);
        tick();
    endtask

    task automatic do_read(input bit id, input logic [1:0] a, input logic [31:0] exp);
        set_req(id, 1'b1, 1'b0, a, 4'h0, 32'h0);
        settle();
        chk("rd_wait", id ? m1_waitrequest : m0_waitrequest, 1'b0);
        tick();
        set_req(id, 1'b0, 1'b0, a, 4'h0, 32'h0);
        tick();
        tick();
        settle();
        chk("rd_valid", id ? m1_readdatavalid : m0_readdatavalid, 1'b1);
        chk("rd_other_valid", id ? m0_readdatavalid : m1_readdatavalid, 1'b0);
        chk("rd_data", id ? m1_readdata : m0_readdata, exp);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
        tick();
        settle();
        chk("rst_m0_wait_forced", m0_waitrequest, 1'b1);
        chk("rst_m1_wait", m1_waitrequest, 1'b1);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_address, 2'd0);
        chk("rst_mem_be", mem_byteenable, 4'h0);
        chk("rst_mem_wdata", mem_writedata, 32'h0);
        chk("rst_m0_rdata", m0_readdata, 32'h0);
        chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
        m0_read = 1'b0;
        tick();
        reset_n = 1'b1;

        // m0 writes DEADBEEF to addr 2, cycle by cycle
        set_req(1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF);
        settle();
        chk("c0_m0_wait", m0_waitrequest, 1'b0);
        chk("c0_m1_wait", m1_waitrequest, 1'b1);
        tick();
        m0_write = 1'b0;
        settle();
        chk("c1_cs", mem_chipselect, 1'b1);
        chk("c1_write", mem_write, 1'b1);
        chk("c1_addr", mem_address, 2'd2);
        chk("c1_be", mem_byteenable, 4'hF);
        chk("c1_wdata", mem_writedata, 32'hDEADBEEF);
        chk("c1_m0_wait", m0_waitrequest, 1'b1);
        tick();
        // read back from addr 2, accepted in the first IDLE cycle after the write
        set_req(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0);
        settle();
        chk("c2_cs", mem_chipselect, 1'b0);
        chk("c2_addr_hold", mem_address, 2'd2);
        chk("c2_m0_wait", m0_waitrequest, 1'b0);
        tick();
        m0_read = 1'b0;
        settle();
        chk("c3_cs", mem_chipselect, 1'b1);
        chk("c3_write", mem_write, 1'b0);
        tick();
        settle();
        chk("c4_rdv", m0_readdatavalid, 1'b0);
        tick();
        settle();
        chk("c5_m0_rdv", m0_readdatavalid, 1'b1);
        chk("c5_m0_rdata", m0_readdata, 32'hDEADBEEF);
        chk("c5_m1_rdv", m1_readdatavalid, 1'b0);
        tick();
        settle();
        chk("c6_m0_rdv_low", m0_readdatavalid, 1'b0);
        chk("c6_m0_rdata_hold", m0_readdata, 32'hDEADBEEF);
        tick();

        // partial write over all-ones
        do_write(1'b0, 2'd0, 4'hF, 32'hFFFFFFFF);
        do_write(1'b1, 2'd0, 4'h3, 32'h12345678);
        do_read(1'b1, 2'd0, 32'hFFFF5678);
        do_write(1'b0, 2'd3, 4'hF, 32'h33333333);

        // m1 read+write together: one write, no read pulse
        set_req(1'b1, 1'b1, 1'b1, 2'd1, 4'hF, 32'hAAAA5555);
        settle();
        chk("rw_m1_wait", m1_waitrequest, 1'b0);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 32'hAAAA5555);
        settle();
        chk("rw_mem_write", mem_write, 1'b1);
        chk("rw_mem_addr", mem_address, 2'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rw_no_m1_rdv", m1_readdatavalid, 1'b0);
            tick();
        end
        do_read(1'b0, 2'd1, 32'hAAAA5555);

        // continuous reads from both masters after reset: alternate every 3 cycles
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("rr_m0_wait", m0_waitrequest, (c % 6 == 0) ? 1'b0 : 1'b1);
            chk("rr_m1_wait", m1_waitrequest, (c % 6 == 3) ? 1'b0 : 1'b1);
            chk("rr_m0_rdv", m0_readdatavalid, (c == 3 || c == 9) ? 1'b1 : 1'b0);
            chk("rr_m1_rdv", m1_readdatavalid, (c == 6) ? 1'b1 : 1'b0);
            if (c == 3 || c == 9) chk("rr_m0_rdata", m0_readdata, 32'hAAAA5555);
            if (c == 6) chk("rr_m1_rdata", m1_readdata, 32'h33333333);
            tick();
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();
        tick();
        tick();

        // reset during RDATA of an m0 read; history left pointing at m0
        m0_read = 1'b1;
        tick();
        m0_read = 1'b0;
        tick();
        reset_n = 1'b0;
        settle();
        chk("ar_cs", mem_chipselect, 1'b0);
        chk("ar_mem_addr", mem_address, 2'd0);
        chk("ar_m0_wait", m0_waitrequest, 1'b1);
        chk("ar_m0_rdata", m0_readdata, 32'h0);
        chk("ar_m1_rdata", m1_readdata, 32'h0);
        tick();
        settle();
        chk("ar_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
        m0_read = 1'b1;
        m1_read = 1'b1;
        tick();
        reset_n = 1'b1;
        settle();
        chk("ar_tie_m0_wait", m0_waitrequest, 1'b0);
        chk("ar_tie_m1_wait", m1_waitrequest, 1'b1);
        tick();
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
